// File: rtl/spi_initiator.sv
// spi_initiator: SPI mode-0 (CPOL=0, CPHA=0) initiator driven from a
// valid/ready byte stream. CS stays low across consecutive bytes until a
// byte flagged last has been shifted and the CS hold time has elapsed.
// Optional build macro: SPI_INITIATOR_LSB_FIRST_EN selects LSB-first
// shifting on both mosi_o and miso_i (default is MSB first).
module spi_initiator #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       sclk_o,
    output logic       cs_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int SET_W = $clog2(CS_SETUP + 1);
    localparam int HLD_W = $clog2(CS_HOLD + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(CS_SETUP - 1);
    localparam logic [HLD_W-1:0] HLD_LOAD = HLD_W'(CS_HOLD - 1);

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [HLD_W-1:0] hld_q, hld_d;
    logic [2:0]       bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             last_q, last_d;
    logic [7:0]       tx_sr_q, tx_sr_d;
    logic [7:0]       rx_sr_q, rx_sr_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;

    logic             accept;
    logic [7:0]       tx_shifted;
    logic [7:0]       rx_shifted;

`ifdef SPI_INITIATOR_LSB_FIRST_EN
    // LSB first: bit 0 leaves first, first received bit ends up in bit 0.
    assign mosi_o     = tx_sr_q[0];
    assign tx_shifted = {1'b0, tx_sr_q[7:1]};
    assign rx_shifted = {miso_i, rx_sr_q[7:1]};
`else
    // MSB first on both directions.
    assign mosi_o     = tx_sr_q[7];
    assign tx_shifted = {tx_sr_q[6:0], 1'b0};
    assign rx_shifted = {rx_sr_q[6:0], miso_i};
`endif

    assign tx_ready_o = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign busy_o     = (state_q != ST_IDLE);
    assign cs_o       = (state_q == ST_IDLE);
    assign sclk_o     = sclk_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign accept     = tx_valid_i && tx_ready_o;

    // Next-state logic for the sequencer, clock divider and shift registers.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        set_d      = set_q;
        hld_d      = hld_q;
        bit_d      = bit_q;
        sclk_d     = sclk_q;
        last_d     = last_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_sr_d = tx_data_i;
                    last_d  = tx_last_i;
                    set_d   = SET_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (set_q == '0) begin
                    div_d   = DIV_LOAD;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    set_d = set_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == '0) begin
                    div_d  = DIV_LOAD;
                    sclk_d = ~sclk_q;
                    // Falling sclk edge: sample miso, advance mosi.
                    if (sclk_q) begin
                        rx_sr_d = rx_shifted;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rx_data_d  = rx_shifted;
                            rx_valid_d = 1'b1;
                            hld_d      = HLD_LOAD;
                            state_d    = last_q ? ST_HOLD : ST_WAIT;
                        end else begin
                            tx_sr_d = tx_shifted;
                        end
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_WAIT: begin
                // Next byte skips the setup phase; CS is already low.
                if (accept) begin
                    tx_sr_d = tx_data_i;
                    last_d  = tx_last_i;
                    div_d   = DIV_LOAD;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (hld_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hld_d = hld_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            set_q      <= '0;
            hld_q      <= '0;
            bit_q      <= 3'd0;
            sclk_q     <= 1'b0;
            last_q     <= 1'b0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            set_q      <= set_d;
            hld_q      <= hld_d;
            bit_q      <= bit_d;
            sclk_q     <= sclk_d;
            last_q     <= last_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule

// File: tb/tb_spi_initiator.sv
// tb_spi_initiator: directed bench for spi_initiator with a receive-byte
// scoreboard. One instance uses CLK_DIV=2/CS_SETUP=2/CS_HOLD=2, a second
// uses the minimum parameters of 1.
module tb_spi_initiator;

    localparam int CD  = 2;
    localparam int CSS = 2;
    localparam int CSH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       use_min = 1'b0;
    logic       resp_mode = 1'b0;

    logic       d_tx_valid, d_ready, d_rxv, d_busy, d_sclk, d_cs, d_mosi, d_miso;
    logic [7:0] d_rx_data;
    logic       m_tx_valid, m_ready, m_rxv, m_busy, m_sclk, m_cs, m_mosi;
    logic [7:0] m_rx_data;

    logic       o_sclk, o_cs, o_mosi, o_rxv, o_ready;

    logic [3:0] resp_cnt = 4'd0;
    logic [7:0] resp_byte = 8'h3C;
    logic       resp_bit;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [8:0] txq[$];
    logic [7:0] expq[$];
    int         acc[$], rises[$], falls[$], rxv[$], cs_rise[$], cs_fall[$];
    logic [23:0] mosi_cap;
    logic       sclk_prev, cs_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign d_tx_valid = tx_valid & ~use_min;
    assign m_tx_valid = tx_valid & use_min;
    assign d_miso     = resp_mode ? resp_bit : d_mosi;

    assign o_sclk  = use_min ? m_sclk  : d_sclk;
    assign o_cs    = use_min ? m_cs    : d_cs;
    assign o_mosi  = use_min ? m_mosi  : d_mosi;
    assign o_rxv   = use_min ? m_rxv   : d_rxv;
    assign o_ready = use_min ? m_ready : d_ready;

    spi_initiator #(.CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .tx_valid_i(d_tx_valid), .tx_ready_o(d_ready),
        .tx_data_i(tx_data), .tx_last_i(tx_last),
        .rx_valid_o(d_rxv), .rx_data_o(d_rx_data), .busy_o(d_busy),
        .sclk_o(d_sclk), .cs_o(d_cs), .mosi_o(d_mosi), .miso_i(d_miso)
    );

    spi_initiator #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_min (
        .clk_i(clk), .rst_i(rst),
        .tx_valid_i(m_tx_valid), .tx_ready_o(m_ready),
        .tx_data_i(tx_data), .tx_last_i(tx_last),
        .rx_valid_o(m_rxv), .rx_data_o(m_rx_data), .busy_o(m_busy),
        .sclk_o(m_sclk), .cs_o(m_cs), .mosi_o(m_mosi), .miso_i(m_mosi)
    );

    // Responder model: MSB first, miso changes only after sclk falls.
    always @(negedge d_sclk or posedge d_cs) begin
        if (d_cs) resp_cnt <= 4'd0;
        else      resp_cnt <= resp_cnt + 4'd1;
    end
    assign resp_bit = resp_cnt[3] ? 1'b0 : resp_byte[3'd7 - resp_cnt[2:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_pop(input logic [7:0] got);
        logic [7:0] e;
        checks++;
        assert (expq.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected observed %0h expected no rx_valid", got);
        end
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("sb_rx_data", 32'(got), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (d_rxv) sb_pop(d_rx_data);
        if (m_rxv) sb_pop(m_rx_data);
    end

    task automatic drive_tx();
        if (txq.size() > 0) begin
            tx_valid = 1'b1;
            {tx_last, tx_data} = txq[0];
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] data, input logic last);
        txq.push_back({last, data});
        drive_tx();
    endtask

    task automatic clear_rec();
        acc.delete(); rises.delete(); falls.delete(); rxv.delete();
        cs_rise.delete(); cs_fall.delete();
        mosi_cap  = 24'h0;
        sclk_prev = o_sclk;
        cs_prev   = o_cs;
    endtask

    // Observe n cycles at the falling clk edge, feeding txq on handshakes.
    task automatic run(input int n);
        logic acc_now;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_sclk && !sclk_prev) begin
                rises.push_back(cyc);
                mosi_cap = {mosi_cap[22:0], o_mosi};
            end
            if (!o_sclk && sclk_prev) falls.push_back(cyc);
            if (o_rxv) rxv.push_back(cyc);
            if (o_cs && !cs_prev) cs_rise.push_back(cyc);
            if (!o_cs && cs_prev) cs_fall.push_back(cyc);
            sclk_prev = o_sclk;
            cs_prev   = o_cs;
            acc_now   = tx_valid && o_ready;
            if (acc_now) acc.push_back(cyc + 1);
            @(posedge clk);
            #1;
            if (acc_now) void'(txq.pop_front());
            drive_tx();
        end
    endtask

    initial begin
        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_cs", 32'(d_cs), 32'd1);
        chk("rst_sclk", 32'(d_sclk), 32'd0);
        chk("rst_mosi", 32'(d_mosi), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_ready", 32'(d_ready), 32'd1);
        chk("rst_rxv", 32'(d_rxv), 32'd0);
        chk("rst_rxdata", 32'(d_rx_data), 32'h0);
        chk("rst_min_cs", 32'(m_cs), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single byte A5 with last, loopback
        clear_rec();
        send(8'hA5, 1'b1);
        expq.push_back(8'hA5);
        run(40);
        chk("a5_accepts", 32'(acc.size()), 32'd1);
        chk("a5_cs_fall", 32'(cs_fall[0] - acc[0]), 32'd0);
        chk("a5_first_rise", 32'(rises[0] - acc[0]), 32'(CSS + CD));
        chk("a5_rise_count", 32'(rises.size()), 32'd8);
        chk("a5_mosi_bits", 32'(mosi_cap[7:0]), 32'hA5);
        chk("a5_last_fall", 32'(falls[7] - acc[0]), 32'(CSS + 16 * CD));
        chk("a5_rxv_count", 32'(rxv.size()), 32'd1);
        chk("a5_rxv_time", 32'(rxv[0] - acc[0]), 32'd34);
        chk("a5_cs_rise", 32'(cs_rise[0] - acc[0]), 32'd36);

        // Back-to-back frame 03, 10, FF(last)
        clear_rec();
        send(8'h03, 1'b0); send(8'h10, 1'b0); send(8'hFF, 1'b1);
        expq.push_back(8'h03); expq.push_back(8'h10); expq.push_back(8'hFF);
        run(120);
        chk("b2b_accepts", 32'(acc.size()), 32'd3);
        chk("b2b_acc_gap0", 32'(acc[1] - acc[0]), 32'(CSS + 16 * CD + 1));
        chk("b2b_acc_gap1", 32'(acc[2] - acc[1]), 32'd33);
        chk("b2b_rxv_count", 32'(rxv.size()), 32'd3);
        chk("b2b_rxv_gap0", 32'(rxv[1] - rxv[0]), 32'd33);
        chk("b2b_rxv_gap1", 32'(rxv[2] - rxv[1]), 32'd33);
        chk("b2b_rises", 32'(rises.size()), 32'd24);
        chk("b2b_mosi_bits", 32'(mosi_cap), 32'h0310FF);
        chk("b2b_cs_falls", 32'(cs_fall.size()), 32'd1);
        chk("b2b_cs_rises", 32'(cs_rise.size()), 32'd1);
        chk("b2b_cs_release", 32'(cs_rise[0] - rxv[2]), 32'(CSH));

        // Responder returns 3C
        resp_mode = 1'b1;
        clear_rec();
        send(8'h5A, 1'b1);
        expq.push_back(8'h3C);
        run(45);
        chk("resp_rxv_count", 32'(rxv.size()), 32'd1);
        chk("resp_mosi_bits", 32'(mosi_cap[7:0]), 32'h5A);
        resp_mode = 1'b0;

        // WAIT stall after a non-last byte
        clear_rec();
        send(8'h96, 1'b0);
        expq.push_back(8'h96);
        run(90);
        chk("wait_rises", 32'(rises.size()), 32'd8);
        chk("wait_cs_rises", 32'(cs_rise.size()), 32'd0);
        chk("wait_cs", 32'(d_cs), 32'd0);
        chk("wait_sclk", 32'(d_sclk), 32'd0);
        chk("wait_ready", 32'(d_ready), 32'd1);
        chk("wait_busy", 32'(d_busy), 32'd1);
        clear_rec();
        send(8'h69, 1'b1);
        expq.push_back(8'h69);
        run(45);
        chk("wait_accepts", 32'(acc.size()), 32'd1);
        chk("wait_first_rise", 32'(rises[0] - acc[0]), 32'(CD));
        chk("wait_rxv_time", 32'(rxv[0] - acc[0]), 32'(16 * CD));
        chk("wait_cs_rise", 32'(cs_rise[0] - acc[0]), 32'(16 * CD + CSH));

        // Minimum parameters: two 81 frames offered back to back
        use_min = 1'b1;
        clear_rec();
        send(8'h81, 1'b1); send(8'h81, 1'b1);
        expq.push_back(8'h81); expq.push_back(8'h81);
        run(60);
        chk("min_accepts", 32'(acc.size()), 32'd2);
        chk("min_first_rise", 32'(rises[0] - acc[0]), 32'd2);
        chk("min_fall_after_rise", 32'(falls[0] - rises[0]), 32'd1);
        chk("min_rise_period", 32'(rises[1] - rises[0]), 32'd2);
        chk("min_rises", 32'(rises.size()), 32'd16);
        chk("min_mosi_bits", 32'(mosi_cap[15:0]), 32'h8181);
        chk("min_rxv_time", 32'(rxv[0] - acc[0]), 32'd17);
        chk("min_cs_rise", 32'(cs_rise[0] - acc[0]), 32'd18);
        chk("min_cs_high_gap", 32'(acc[1] - cs_rise[0]), 32'd1);
        use_min = 1'b0;

        // Reset mid-SHIFT on an FF byte: partial byte must be dropped
        clear_rec();
        send(8'hFF, 1'b0);
        run(10);
        chk("mid_busy_before", 32'(d_busy), 32'd1);
        chk("mid_mosi_before", 32'(d_mosi), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(d_cs), 32'd1);
        chk("mid_rst_sclk", 32'(d_sclk), 32'd0);
        chk("mid_rst_mosi", 32'(d_mosi), 32'd0);
        chk("mid_rst_busy", 32'(d_busy), 32'd0);
        chk("mid_rst_rxdata", 32'(d_rx_data), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_rec();
        run(50);
        chk("mid_no_rxv", 32'(rxv.size()), 32'd0);
        chk("mid_ready", 32'(d_ready), 32'd1);
        chk("mid_cs_idle", 32'(d_cs), 32'd1);

        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
